uart_receive: RTL
=================

Name: uart_receive

Overview:
- Serial-to-parallel receiver directly downstream of the UART transmit stage; consumes its serial line.
- Frame format: idle 1, start bit 0, D_WIDTH data bits LSB first, then one or more stop bits of 1.
- Oversamples the line at CLKS_PER_BIT clocks per bit, checks start and stop bits, and presents each received word on a valid/ready output interface.
- Flags framing errors and overruns.

Parameters:
- D_WIDTH, 4: data bits per frame. Must match the transmitter.
- CLKS_PER_BIT, 1: clocks per serial bit. Default 1 matches the transmitter's one-bit-per-clock rate. Must be >= 1.
- HALF (localparam), (CLKS_PER_BIT-1)/2: mid-bit offset.
- C_WIDTH (localparam), max(1,$clog2(CLKS_PER_BIT)): bit-timer width.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- rx  input  1  serial line; idles high
- rx_data  output  D_WIDTH  received word; stable while rx_valid=1
- rx_valid  output  1  word available; held until accepted
- rx_ready  input  1  consumer accepts word when rx_valid&rx_ready
- rx_busy  output  1  frame in progress (state != IDLE)
- frame_err  output  1  one-cycle pulse: stop bit sampled 0
- overrun  output  1  one-cycle pulse: frame completed while rx_valid still 1

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, synchronizer flops=1, counters=0.
  - Outputs: rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun=0.
- Input sync: rx passes through 2 flops (reset value 1) to give rx_s. All decisions use rx_s, so there are 2 cycles of input latency.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - rx_s=0 and HALF=0: go to DATA, cnt=0, bit_idx=0.
  - rx_s=0 and HALF>0: go to START, cnt=1.
  - Otherwise stay in IDLE.
- START:
  - cnt==HALF and rx_s=0: go to DATA, cnt=0, bit_idx=0.
  - cnt==HALF and rx_s=1: glitch; return to IDLE with no flags.
  - Otherwise cnt++.
- DATA:
  - cnt==CLKS_PER_BIT-1: shift_reg={rx_s, shift_reg[D_WIDTH-1:1]} (LSB first), cnt=0, bit_idx++.
  - After the D_WIDTH-th sample, go to STOP.
  - Otherwise cnt++.
  - Each sample is therefore taken mid-bit, CLKS_PER_BIT cycles after the previous mid-point.
- STOP, at cnt==CLKS_PER_BIT-1:
  - rx_s=1 and rx_valid=0, or rx_valid&rx_ready this cycle: rx_data<=shift_reg, rx_valid<=1 on the next edge; go to IDLE.
  - rx_s=1 and rx_valid=1 with rx_ready=0: overrun pulses 1 cycle; new word dropped; old rx_data retained; go to IDLE.
  - rx_s=0: frame_err pulses 1 cycle; word discarded; go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then go to IDLE. This blocks false starts on a held-low (break) line.
- Handshake:
  - rx_valid clears on the edge after rx_valid&rx_ready.
  - A new word and an accept in the same cycle: new word loads and rx_valid stays 1, with no overrun.
- rx_busy is combinational: 1 in every state except IDLE.
- Back-to-back frames: IDLE accepts a new start bit in the cycle after STOP, so there is no dead cycle beyond one stop bit.
- Counters: cnt is C_WIDTH bits and never exceeds CLKS_PER_BIT-1. bit_idx is $clog2(D_WIDTH+1) bits and resets in IDLE.
- Reset mid-frame: everything returns to reset values immediately. A partial frame is never reported.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP, WAIT_IDLE}.
  - Constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
  - The transmitter's start/stop constants move into this package as well.
- Sub-module uart_sync: 2-flop synchronizer with parameterised reset value 1, async active-low reset. The remaining logic is a single module.

Test Plan:
- CLKS_PER_BIT=1, rx_ready=1; drive rx = 1,0,0,1,0,1,1,1 (word 4'hA) -> rx_valid=1 for exactly one cycle, rx_data=4'hA, frame_err=0, rx_valid rising 3 cycles after the stop bit enters rx.
- Back-to-back frames 4'h3 then 4'hC with one stop bit each, rx_ready=1 -> two valid pulses carrying 3 then C, no errors.
- rx_ready=0; send 4'h5, then 4'h9 -> rx_data stays 4'h5, rx_valid stays 1, overrun pulses once at the second stop sample. Raising rx_ready then clears rx_valid on the next edge.
- Frame 4'hF with stop bit forced 0, line held low 5 cycles then released high -> frame_err pulses once, no rx_valid, no new start until rx_s returns to 1; a following frame 4'h6 is received correctly.
- CLKS_PER_BIT=4: a 1-cycle low glitch on idle rx -> return to IDLE with no flags; a full frame 4'hB (4 clocks/bit) -> rx_data=4'hB.
- Drop rst to 0 during the DATA state of frame 4'h7 -> all outputs 0 asynchronously, no rx_valid. After release, frame 4'h2 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels and receiver FSM states.
// Start/stop levels are common to the transmit and receive stages.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Counter width that stays at least one bit wide for tiny ranges.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer with a configurable reset level.
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receive.sv
// UART receiver: oversampled start/data/stop framing with a valid/ready
// output, framing-error and overrun pulses. Assumes D_WIDTH >= 2.
module uart_receive
    import uart_pkg::*;
#(
    parameter int D_WIDTH      = 4,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic               rx_busy,
    output logic               frame_err,
    output logic               overrun
);

    localparam int HALF    = (CLKS_PER_BIT - 1) / 2;
    localparam int C_WIDTH = clog2_min1(CLKS_PER_BIT);
    localparam int B_WIDTH = $clog2(D_WIDTH + 1);

    localparam logic [C_WIDTH-1:0] CNT_LAST = C_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [C_WIDTH-1:0] CNT_HALF = C_WIDTH'(HALF);
    localparam logic [C_WIDTH-1:0] CNT_ONE  = C_WIDTH'(1);
    localparam logic [B_WIDTH-1:0] BIT_LAST = B_WIDTH'(D_WIDTH - 1);

    rx_state_t          state, state_next;
    logic [C_WIDTH-1:0] cnt, cnt_next;
    logic [B_WIDTH-1:0] bit_idx, bit_idx_next;
    logic [D_WIDTH-1:0] shift_reg, shift_next;
    logic               rx_s;
    logic               load;
    logic               ferr_next;
    logic               ovr_next;

    uart_sync #(.RST_VAL(IDLE_LEVEL)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // State, bit timer, bit index and shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
        end
    end

    // Framing decisions; every sample is taken from the synchronized line.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
        load         = 1'b0;
        ferr_next    = 1'b0;
        ovr_next     = 1'b0;
        case (state)
            IDLE: begin
                cnt_next     = '0;
                bit_idx_next = '0;
                if (rx_s == START_BIT) begin
                    // With no mid-bit offset the first low cycle is already
                    // the start-bit midpoint, so skip the START check.
                    if (HALF == 0) begin
                        state_next = DATA;
                    end else begin
                        state_next = START;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    // Line back high at mid-start is a glitch: drop silently.
                    state_next   = (rx_s == START_BIT) ? DATA : IDLE;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    shift_next   = {rx_s, shift_reg[D_WIDTH-1:1]};
                    cnt_next     = '0;
                    bit_idx_next = bit_idx + B_WIDTH'(1);
                    if (bit_idx == BIT_LAST) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (rx_s == STOP_BIT) begin
                        state_next = IDLE;
                        // A word being accepted this cycle frees the slot.
                        if (!rx_valid || rx_ready) begin
                            load = 1'b1;
                        end else begin
                            ovr_next = 1'b1;
                        end
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            WAIT_IDLE: begin
                // Hold off on a break so the low line is not seen as a start.
                if (rx_s == IDLE_LEVEL) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output word holding register and valid/ready handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (load) begin
            rx_data  <= shift_reg;
            rx_valid <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

    // Single-cycle error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_next;
            overrun   <= ovr_next;
        end
    end

    assign rx_busy = (state != IDLE);

endmodule
